// File: rtl/bram_port_responder.sv
// Dual-port word RAM answering the BRAM sequencer (byte lanes, 1-cycle reads) and the decode core,
// with per-burst length/direction reporting for the sequencer port.
module bram_port_responder #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en,
  input  logic [3:0]        ram_we,
  input  logic [31:0]       ram_addr,
  input  logic [31:0]       ram_wr_data,
  output logic [31:0]       ram_rd_data,
  output logic              ram_rd_valid,
  input  logic              core_en,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wr_data,
  output logic [31:0]       core_rd_data,
  output logic              core_rd_valid,
  input  logic              err_clr,
  output logic              addr_err,
  output logic              collision,
  output logic              burst_done,
  output logic [CNT_W-1:0]  burst_words,
  output logic              burst_is_write
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] seq_idx;
  logic              seq_oor, seq_wr, seq_rd, core_wr, core_rd, same_word;
  logic              unused_addr_bits;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              finish;

  assign seq_idx          = ram_addr[ADDR_W+1:2];
  assign seq_oor          = |ram_addr[31:ADDR_W+2];
  assign unused_addr_bits = ^ram_addr[1:0];
  assign seq_wr           = ram_en && (ram_we != 4'h0) && !seq_oor;
  assign seq_rd           = ram_en && (ram_we == 4'h0);
  assign same_word        = seq_wr && core_en && core_we && (seq_idx == core_addr);
  // On a same-word clash the sequencer owns the word; the core write is dropped whole.
  assign core_wr          = core_en && core_we && !same_word;
  assign core_rd          = core_en && !core_we;

  // Storage is deliberately unreset; reads below see pre-edge contents (read-first).
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (seq_wr && ram_we[i]) mem[seq_idx][8*i +: 8] <= ram_wr_data[8*i +: 8];
    end
    if (core_wr) mem[core_addr] <= core_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_rd_data   <= 32'h0;
      ram_rd_valid  <= 1'b0;
      core_rd_data  <= 32'h0;
      core_rd_valid <= 1'b0;
      addr_err      <= 1'b0;
      collision     <= 1'b0;
    end else begin
      ram_rd_valid  <= seq_rd;
      core_rd_valid <= core_rd;
      collision     <= same_word;
      if (seq_rd) ram_rd_data <= seq_oor ? 32'h0 : mem[seq_idx];
      if (core_rd) core_rd_data <= mem[core_addr];
      if (ram_en && seq_oor) addr_err <= 1'b1;
      else if (err_clr)      addr_err <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (ram_en) begin
          state_nxt = (ram_we == 4'h0) ? RD : WR;
          cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin
        if (!ram_en) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if ((ram_we != 4'h0) != (state == WR)) begin
          finish    = 1'b1;
          state_nxt = (ram_we == 4'h0) ? RD : WR;
          cnt_nxt   = CNT_W'(1);
        end else if (cnt != {CNT_W{1'b1}}) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      burst_done     <= 1'b0;
      burst_words    <= '0;
      burst_is_write <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      burst_done <= finish;
      if (finish) begin
        burst_words    <= cnt;
        burst_is_write <= (state == WR);
      end
    end
  end

endmodule

// File: tb/tb_bram_port_responder.sv
// Directed bench for bram_port_responder: sequencer/core access, lanes, collision, range, bursts, reset.
module tb_bram_port_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wr_data, ram_rd_data;
  logic        ram_rd_valid;
  logic        core_en, core_we;
  logic [9:0]  core_addr;
  logic [31:0] core_wr_data, core_rd_data;
  logic        core_rd_valid;
  logic        err_clr, addr_err, collision, burst_done, burst_is_write;
  logic [15:0] burst_words;

  int tests = 0;
  int fails = 0;

  bram_port_responder #(.ADDR_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data), .ram_rd_valid(ram_rd_valid),
    .core_en(core_en), .core_we(core_we), .core_addr(core_addr), .core_wr_data(core_wr_data),
    .core_rd_data(core_rd_data), .core_rd_valid(core_rd_valid),
    .err_clr(err_clr), .addr_err(addr_err), .collision(collision),
    .burst_done(burst_done), .burst_words(burst_words), .burst_is_write(burst_is_write)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic seq(input logic en, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] data);
    ram_en = en; ram_we = we; ram_addr = addr; ram_wr_data = data;
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    seq(1'b0, 4'h0, 32'h0, 32'h0);
    core_en = 1'b0; core_we = 1'b0; core_addr = '0; core_wr_data = '0;
    tick(); tick();
    check("rst_rd_data", ram_rd_data, 32'h0);
    check("rst_rd_valid", 32'(ram_rd_valid), 32'h0);
    check("rst_core_valid", 32'(core_rd_valid), 32'h0);
    check("rst_addr_err", 32'(addr_err), 32'h0);
    check("rst_burst_words", 32'(burst_words), 32'h0);
    check("rst_burst_done", 32'(burst_done), 32'h0);
    rst = 1'b0;
    tick();

    // 8-word write burst then 8-word read burst
    for (int i = 0; i < 8; i++) begin
      seq(1'b1, 4'hF, 32'(i * 4), 32'hA000_0000 + 32'(i));
      tick();
    end
    seq(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("wr_burst_done", 32'(burst_done), 32'h1);
    check("wr_burst_words", 32'(burst_words), 32'd8);
    check("wr_burst_is_write", 32'(burst_is_write), 32'h1);
    for (int i = 0; i < 8; i++) begin
      seq(1'b1, 4'h0, 32'(i * 4), 32'h0);
      tick();
      check("rd_valid", 32'(ram_rd_valid), 32'h1);
      check("rd_data", ram_rd_data, 32'hA000_0000 + 32'(i));
    end
    seq(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("rd_valid_drop", 32'(ram_rd_valid), 32'h0);
    check("rd_data_hold", ram_rd_data, 32'hA000_0007);
    check("rd_burst_done", 32'(burst_done), 32'h1);
    check("rd_burst_words", 32'(burst_words), 32'd8);
    check("rd_burst_is_write", 32'(burst_is_write), 32'h0);
    tick();
    check("burst_done_pulse", 32'(burst_done), 32'h0);

    // Byte-lane write
    seq(1'b1, 4'hF, 32'h0C, 32'h1122_3344); tick();
    seq(1'b1, 4'b0101, 32'h0C, 32'hAABB_CCDD); tick();
    seq(1'b1, 4'h0, 32'h0C, 32'h0); tick();
    check("lane_merge", ram_rd_data, 32'h11BB_33DD);
    seq(1'b0, 4'h0, 32'h0, 32'h0); tick();

    // Same-word collision: sequencer wins
    core_en = 1'b1; core_we = 1'b1; core_addr = 10'd7; core_wr_data = 32'h5;
    seq(1'b1, 4'hF, 32'h1C, 32'h9);
    tick();
    check("collision_pulse", 32'(collision), 32'h1);
    core_we = 1'b0; core_addr = 10'd7;
    seq(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("collision_clear", 32'(collision), 32'h0);
    check("core_rd_valid", 32'(core_rd_valid), 32'h1);
    check("collision_winner", core_rd_data, 32'h9);
    core_en = 1'b0;
    tick();
    check("core_valid_drop", 32'(core_rd_valid), 32'h0);

    // Different words written by both ports in the same cycle; read-first check
    core_en = 1'b1; core_we = 1'b1; core_addr = 10'd20; core_wr_data = 32'h1234_5678;
    seq(1'b1, 4'hF, 32'h54, 32'hCAFE_0001);
    tick();
    check("no_collision", 32'(collision), 32'h0);
    core_we = 1'b0; core_addr = 10'd20;
    seq(1'b1, 4'hF, 32'h54, 32'hCAFE_0002);
    tick();
    check("core_wr_applied", core_rd_data, 32'h1234_5678);
    core_en = 1'b0;
    seq(1'b1, 4'h0, 32'h54, 32'h0); tick();
    check("seq_wr_second", ram_rd_data, 32'hCAFE_0002);
    core_en = 1'b1; core_we = 1'b1; core_addr = 10'd21; core_wr_data = 32'h0BAD_0BAD;
    seq(1'b1, 4'h0, 32'h54, 32'h0); tick();
    core_we = 1'b0; tick();
    check("core_read_first", core_rd_data, 32'h0BAD_0BAD);
    core_en = 1'b0;
    seq(1'b0, 4'h0, 32'h0, 32'h0); tick();

    // Out-of-range access
    seq(1'b1, 4'h0, 32'h0000_1000, 32'h0); tick();
    check("oor_rd_data", ram_rd_data, 32'h0);
    check("oor_rd_valid", 32'(ram_rd_valid), 32'h1);
    check("oor_addr_err", 32'(addr_err), 32'h1);
    seq(1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF); tick();
    seq(1'b0, 4'h0, 32'h0, 32'h0); tick();
    check("addr_err_sticky", 32'(addr_err), 32'h1);
    seq(1'b1, 4'h0, 32'h0, 32'h0); err_clr = 1'b1; tick();
    check("oor_no_write", ram_rd_data, 32'hA000_0000);
    check("addr_err_clr", 32'(addr_err), 32'h0);
    err_clr = 1'b1;
    seq(1'b1, 4'h0, 32'h8000_0000, 32'h0); tick();
    check("addr_err_set_wins", 32'(addr_err), 32'h1);
    err_clr = 1'b0;
    seq(1'b0, 4'h0, 32'h0, 32'h0); tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    tick();

    // Direction switch with ram_en held
    for (int i = 0; i < 3; i++) begin
      seq(1'b1, 4'h0, 32'(i * 4), 32'h0); tick();
    end
    seq(1'b1, 4'hF, 32'h78, 32'h1); tick();
    check("sw_done_rd", 32'(burst_done), 32'h1);
    check("sw_words_rd", 32'(burst_words), 32'd3);
    check("sw_dir_rd", 32'(burst_is_write), 32'h0);
    seq(1'b1, 4'hF, 32'h7C, 32'h2); tick();
    check("sw_done_gap", 32'(burst_done), 32'h0);
    seq(1'b0, 4'h0, 32'h0, 32'h0); tick();
    check("sw_done_wr", 32'(burst_done), 32'h1);
    check("sw_words_wr", 32'(burst_words), 32'd2);
    check("sw_dir_wr", 32'(burst_is_write), 32'h1);
    tick();

    // Reset in the middle of a read burst
    for (int i = 0; i < 4; i++) begin
      seq(1'b1, 4'h0, 32'(i * 4), 32'h0); tick();
    end
    rst = 1'b1;
    seq(1'b0, 4'h0, 32'h0, 32'h0);
    #2;
    check("mid_rst_rd_valid", 32'(ram_rd_valid), 32'h0);
    check("mid_rst_rd_data", ram_rd_data, 32'h0);
    check("mid_rst_words", 32'(burst_words), 32'h0);
    tick();
    check("mid_rst_no_done", 32'(burst_done), 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_no_done", 32'(burst_done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      seq(1'b1, 4'h0, 32'(i * 4), 32'h0); tick();
    end
    seq(1'b0, 4'h0, 32'h0, 32'h0); tick();
    check("post_rst_done", 32'(burst_done), 32'h1);
    check("post_rst_words", 32'(burst_words), 32'd3);
    check("post_rst_dir", 32'(burst_is_write), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bram_port_responder.md
# bram_port_responder

Memory-side responder for the 32-bit BRAM port driven by the decoder's BRAM sequencer. Owns a DEPTH-word single-clock RAM, answers sequencer reads/writes with 1-cycle read latency and byte-lane write enables, and exposes a second word-addressed port to the decode core. Tracks each sequencer burst and reports its length and direction on completion.

## Interface
- ADDR_W, 10, word-index width; DEPTH = 2**ADDR_W words
- CNT_W, 16, burst word-counter width

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ram_en  in  1  sequencer port enable
- ram_we  in  4  byte write enables; 0 = read
- ram_addr  in  32  byte address; bits [1:0] ignored
- ram_wr_data  in  32  write data
- ram_rd_data  out  32  read data
- ram_rd_valid  out  1  ram_rd_data valid this cycle
- core_en  in  1  core port enable
- core_we  in  1  core full-word write (1) / read (0)
- core_addr  in  ADDR_W  core word index
- core_wr_data  in  32  core write data
- core_rd_data  out  32  core read data
- core_rd_valid  out  1  core_rd_data valid this cycle
- err_clr  in  1  clears addr_err
- addr_err  out  1  sticky: sequencer accessed out of range
- collision  out  1  one-cycle pulse: both ports wrote same word
- burst_done  out  1  one-cycle pulse: a sequencer burst ended
- burst_words  out  CNT_W  words accessed in last finished burst
- burst_is_write  out  1  direction of last finished burst

## Operation
- Word index = ram_addr[ADDR_W+1:2]. Out of range when ram_addr[31:ADDR_W+2] != 0: access ignored (no write), read returns 32'h0 with valid, addr_err set. addr_err clears on err_clr; set wins if both same cycle.
- Write: for each lane i with ram_we[i]=1, byte i of word <= ram_wr_data byte i. Core write updates all 4 bytes.
- Read-first: read of a word written in the same cycle (either port) returns the old contents.
- Both ports write the same word same cycle: sequencer write applies (its enabled lanes only), core write dropped entirely, collision pulses next cycle. Different words: both apply.
- RAM contents are not reset.
- Burst FSM, states IDLE, RD, WR:
  - IDLE: ram_en=1 -> RD if ram_we==0 else WR; counter <= 1.
  - RD/WR with ram_en=1, same direction: counter +1, saturating at all-ones.
  - RD/WR with ram_en=1, direction changes: current burst finishes (capture, pulse), enter other state, counter <= 1.
  - RD/WR with ram_en=0: finish, go IDLE.
  - Finish: burst_words <= counter, burst_is_write <= (state==WR), burst_done pulse in the following cycle.
- Out-of-range accesses still count toward the burst.

## Timing
- Read latency 1: ram_en=1, ram_we=0 at edge N -> ram_rd_data/ram_rd_valid at N+1. Same for core port. Data holds last value when valid low.
- ram_rd_valid/core_rd_valid high exactly one cycle per read issued; back-to-back reads give continuous valid.
- burst_done, burst_words, burst_is_write, collision update together on the edge after the terminating/colliding cycle; burst_words/burst_is_write hold until next finish.
- Reset values: ram_rd_data 0, ram_rd_valid 0, core_rd_data 0, core_rd_valid 0, addr_err 0, collision 0, burst_done 0, burst_words 0, burst_is_write 0, FSM IDLE, counter 0.
- Reset mid-burst: FSM to IDLE immediately, no burst_done emitted; in-flight read valid dropped.

## Test plan
- Sequencer writes 8 words 0xA0000000+i at addr 0x00..0x1C (we=4'hF), then reads same range -> ram_rd_data returns each value 1 cycle after its address; burst_done twice, burst_words=8, burst_is_write 1 then 0.
- Byte lanes: word 3 = 0x11223344, write 0xAABBCCDD with we=4'b0101 -> read returns 0x11BB33DD.
- Same-word collision: core writes 0x5 and sequencer writes 0x9 to word 7 same cycle -> word 7 = 0x9, collision pulses once.
- Out of range: read addr 0x00001000 with ADDR_W=10 -> ram_rd_data 0, addr_err 1 stays set until err_clr; write there leaves word 0 unchanged.
- Direction switch with ram_en held: 3 reads then 2 writes, then en low -> burst_done pulses twice, burst_words 3 (is_write 0) then 2 (is_write 1).
- Assert rst after 4 words of a 10-word read burst -> all outputs 0, no burst_done; next burst counts from 1.
